ps2_scancode_decoder: RTL

PS2_SCANCODE_DECODER -- requirements
Module: ps2_scancode_decoder

---
 rtl/ps2_pkg.sv | 14 +
 rtl/ps2_frame_check.sv | 11 +
 rtl/ps2_scancode_decoder.sv | 82 ++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// PS/2 scancode decoding: prefix byte values and the prefix-tracking state type.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } prefix_state_t;

endpackage

// File: rtl/ps2_frame_check.sv
// Combinational 11-bit PS/2 frame check: start low, stop high, odd parity over data+parity.
module ps2_frame_check (
    input  logic [10:0] frame,
    output logic        frame_ok,
    output logic [7:0]  data
);

    assign data     = frame[8:1];
    assign frame_ok = ~frame[0] & frame[10] & (^frame[9:1]);

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Strips E0/F0 prefixes into a single-entry key event buffer; event visible 1 cycle after frame_stb.
// Valid/ready output; a new event arriving while one is stalled is dropped and flagged as overrun.
module ps2_scancode_decoder
    import ps2_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [10:0]          frame,
    input  logic                 frame_stb,
    input  logic                 key_ready,
    output logic                 key_valid,
    output logic [7:0]           key_code,
    output logic                 key_release,
    output logic                 key_ext,
    output logic                 frame_err,
    output logic                 overrun,
    output logic [ERR_CNT_W-1:0] err_count
);

    logic          frame_ok;
    logic [7:0]    data;
    prefix_state_t state;
    logic          is_prefix;
    logic          stalled;
    logic          err_inc;

    ps2_frame_check u_frame_check (
        .frame    (frame),
        .frame_ok (frame_ok),
        .data     (data)
    );

    assign is_prefix = (data == PS2_EXT) || (data == PS2_BRK);
    assign stalled   = key_valid & ~key_ready;
    // At most one error per frame: a bad frame never reaches the overrun path.
    assign err_inc   = frame_stb & (~frame_ok | (~is_prefix & stalled));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            key_valid   <= 1'b0;
            key_code    <= 8'h00;
            key_release <= 1'b0;
            key_ext     <= 1'b0;
            frame_err   <= 1'b0;
            overrun     <= 1'b0;
            err_count   <= '0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (key_valid && key_ready) begin
                key_valid <= 1'b0;
            end
            if (frame_stb) begin
                if (!frame_ok) begin
                    frame_err <= 1'b1;
                    state     <= IDLE;
                end else if (data == PS2_EXT) begin
                    state <= (state == BRK || state == EXT_BRK) ? EXT_BRK : EXT;
                end else if (data == PS2_BRK) begin
                    state <= (state == EXT || state == EXT_BRK) ? EXT_BRK : BRK;
                end else begin
                    state <= IDLE;
                    if (stalled) begin
                        overrun <= 1'b1;
                    end else begin
                        key_valid   <= 1'b1;
                        key_code    <= data;
                        key_release <= (state == BRK) || (state == EXT_BRK);
                        key_ext     <= (state == EXT) || (state == EXT_BRK);
                    end
                end
            end
            if (err_inc && (err_count != '1)) begin
                err_count <= err_count + ERR_CNT_W'(1);
            end
        end
    end

endmodule
